// File: rtl/regfile_pkg.sv
// Shared register-file constants: default widths, zero-register index, register count.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned ZERO_REG   = 0;

    function automatic int unsigned num_regs(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/decoder_n.sv
// Binary address to one-hot decoder with enable.
module decoder_n
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic                          en,
    input  logic [ADDR_W-1:0]             addr,
    output logic [num_regs(ADDR_W)-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port and a
// per-register busy scoreboard for outstanding writes.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned BYPASS = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [ADDR_W-1:0]           rs_addr,
    input  logic [ADDR_W-1:0]           rt_addr,
    output logic [DATA_W-1:0]           rs_data,
    output logic [DATA_W-1:0]           rt_data,
    output logic                        rs_busy,
    output logic                        rt_busy,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        iss_en,
    input  logic [ADDR_W-1:0]           iss_addr,
    output logic [num_regs(ADDR_W)-1:0] busy_vec
);

    localparam int unsigned NUM_REGS = num_regs(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam bit BYP = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wr_dec;
    logic [NUM_REGS-1:0] iss_dec;
    logic                rs_fwd;
    logic                rt_fwd;

    decoder_n #(.ADDR_W(ADDR_W)) u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_dec)
    );

    decoder_n #(.ADDR_W(ADDR_W)) u_iss_dec (
        .en     (iss_en),
        .addr   (iss_addr),
        .onehot (iss_dec)
    );

    // Register storage; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                if (wr_dec[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Scoreboard: a new issue wins over a same-cycle writeback; bit 0 never sets.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~wr_dec) | iss_dec) & ~NUM_REGS'(1);
        end
    end

    assign rs_fwd = BYP && wr_en && (wr_addr == rs_addr);
    assign rt_fwd = BYP && wr_en && (wr_addr == rt_addr);

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == ZERO_ADDR) begin
            rs_data = '0;
        end else if (rs_fwd) begin
            rs_data = wr_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == ZERO_ADDR) begin
            rt_data = '0;
        end else if (rt_fwd) begin
            rt_data = wr_data;
        end
    end

    // A forwarded operand is no longer a hazard.
    assign rs_busy  = busy[rs_addr] & ~rs_fwd;
    assign rt_busy  = busy[rt_addr] & ~rt_fwd;
    assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb, both bypass variants side by side.
module tb_reg_file_sb;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned NR = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] rs_addr = '0, rt_addr = '0, wr_addr = '0, iss_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0, iss_en = 1'b0;

    logic [DW-1:0] rs_data1, rt_data1, rs_data0, rt_data0;
    logic          rs_busy1, rt_busy1, rs_busy0, rt_busy0;
    logic [NR-1:0] busy_vec1, busy_vec0;

    int tests = 0;
    int errors = 0;

    // Reference state: plain arrays of register contents and pending flags.
    int mem [NR];
    bit pend [NR];

    always #5 clock = ~clock;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_byp (
        .clock(clock), .reset_n(reset_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data1), .rt_data(rt_data1),
        .rs_busy(rs_busy1), .rt_busy(rt_busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec1)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nob (
        .clock(clock), .reset_n(reset_n),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data0), .rt_data(rt_data0),
        .rs_busy(rs_busy0), .rt_busy(rt_busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_vec(busy_vec0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_data(input int addr, input bit byp);
        if (addr == 0) return 0;
        if (byp && wr_en && int'(wr_addr) == addr) return int'(wr_data);
        return mem[addr];
    endfunction

    function automatic int exp_busy(input int addr, input bit byp);
        if (byp && wr_en && int'(wr_addr) == addr) return 0;
        return int'(pend[addr]);
    endfunction

    function automatic int exp_vec();
        int v = 0;
        for (int i = 0; i < int'(NR); i++) if (pend[i]) v += (1 << i);
        return v;
    endfunction

    task automatic check_ports(input string ph);
        check({ph, "_rs_data_byp"}, 32'(rs_data1), exp_data(int'(rs_addr), 1'b1));
        check({ph, "_rt_data_byp"}, 32'(rt_data1), exp_data(int'(rt_addr), 1'b1));
        check({ph, "_rs_busy_byp"}, 32'(rs_busy1), exp_busy(int'(rs_addr), 1'b1));
        check({ph, "_rt_busy_byp"}, 32'(rt_busy1), exp_busy(int'(rt_addr), 1'b1));
        check({ph, "_rs_data_nob"}, 32'(rs_data0), exp_data(int'(rs_addr), 1'b0));
        check({ph, "_rt_data_nob"}, 32'(rt_data0), exp_data(int'(rt_addr), 1'b0));
        check({ph, "_rs_busy_nob"}, 32'(rs_busy0), exp_busy(int'(rs_addr), 1'b0));
        check({ph, "_rt_busy_nob"}, 32'(rt_busy0), exp_busy(int'(rt_addr), 1'b0));
        check({ph, "_vec_byp"}, 32'(busy_vec1), exp_vec());
        check({ph, "_vec_nob"}, 32'(busy_vec0), exp_vec());
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NR); i++) begin
            mem[i] = 0;
            pend[i] = 1'b0;
        end
    endtask

    // Apply inputs mid-low-phase and check the combinational view before the edge.
    task automatic drive(input bit we, input int wa, input int wd,
                         input bit ie, input int ia, input int ra, input int ta);
        @(negedge clock);
        wr_en = we;    wr_addr = AW'(wa);  wr_data = DW'(wd);
        iss_en = ie;   iss_addr = AW'(ia);
        rs_addr = AW'(ra); rt_addr = AW'(ta);
        #1;
        check_ports("pre");
    endtask

    // Advance the model through one rising edge and re-check.
    task automatic edge_step();
        @(posedge clock);
        if (wr_en && wr_addr != 0) begin
            mem[int'(wr_addr)] = int'(wr_data);
            pend[int'(wr_addr)] = 1'b0;
        end
        if (iss_en && iss_addr != 0) pend[int'(iss_addr)] = 1'b1;
        #1;
        check_ports("post");
    endtask

    initial begin
        model_clear();
        rs_addr = 3'd3;
        rt_addr = 3'd5;
        #3;
        check("reset_rs_data", 32'(rs_data1), 0);
        check("reset_rt_data", 32'(rt_data1), 0);
        check("reset_vec", 32'(busy_vec1), 0);
        check("reset_busy", 32'({rs_busy1, rt_busy0}), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Write then read, with the zero register on the other port.
        drive(1, 2, 'hA5, 0, 0, 2, 0); edge_step();
        drive(0, 0, 0, 0, 0, 2, 0);
        check("wr_rd_rs", 32'(rs_data1), 'hA5);
        check("wr_rd_rt_zero", 32'(rt_data1), 0);
        edge_step();

        // Writes and issues to register 0 are ignored.
        drive(1, 0, 'hFF, 1, 0, 0, 0); edge_step();
        check("zero_rs", 32'(rs_data1), 0);
        check("zero_busy0", 32'(busy_vec1[0]), 0);

        // Same-cycle write forwarding versus stored value.
        drive(1, 4, 'h11, 0, 0, 0, 0); edge_step();
        drive(1, 4, 'h22, 0, 0, 4, 4);
        check("byp_fwd", 32'(rs_data1), 'h22);
        check("nob_old", 32'(rs_data0), 'h11);
        edge_step();
        check("nob_new", 32'(rs_data0), 'h22);

        // Scoreboard set, set-beats-clear, then clear.
        drive(0, 0, 0, 1, 6, 6, 6); edge_step();
        check("sb_set_vec", 32'(busy_vec1), 'h40);
        check("sb_set_rs_busy", 32'(rs_busy1), 1);
        drive(1, 6, 'h33, 1, 6, 6, 1); edge_step();
        check("sb_setclr_vec", 32'(busy_vec1), 'h40);
        drive(1, 6, 'h44, 0, 0, 1, 2); edge_step();
        check("sb_clr_vec", 32'(busy_vec1), 0);

        // Async reset mid-operation.
        drive(1, 3, 'h7E, 1, 3, 3, 3); edge_step();
        drive(0, 0, 0, 1, 2, 3, 2); edge_step();
        check("pre_rst_vec", 32'(busy_vec1), 'h0C);
        check("pre_rst_reg3", 32'(rs_data1), 'h7E);
        drive(0, 0, 0, 0, 0, 3, 2);
        #1;
        reset_n = 1'b0;
        #1;
        model_clear();
        check("async_rst_vec", 32'(busy_vec1), 0);
        check("async_rst_reg3", 32'(rs_data1), 0);
        check("async_rst_reg3_nob", 32'(rs_data0), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(bit'($urandom_range(1, 0)), int'($urandom_range(NR - 1, 0)),
                  int'($urandom_range(255, 0)), bit'($urandom_range(1, 0)),
                  int'($urandom_range(NR - 1, 0)), int'($urandom_range(NR - 1, 0)),
                  int'($urandom_range(NR - 1, 0)));
            edge_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised multi-register file with two combinational read ports and one clocked write port.
- Register 0 is hardwired to zero.
- A per-register busy scoreboard tracks outstanding writes: an issuing instruction marks its destination busy, and writeback clears it.
- Sits between decode and execute in the single-cycle/multi-cycle datapath. It replaces the fixed 4-entry, 4-bit file and supplies operand-hazard information to control.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = the read returns the old stored value.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- rs_addr  in  ADDR_W  read port A address.
- rt_addr  in  ADDR_W  read port B address.
- rs_data  out  DATA_W  read port A data.
- rt_data  out  DATA_W  read port B data.
- rs_busy  out  1  port A register has a pending write.
- rt_busy  out  1  port B register has a pending write.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- iss_en  in  1  an instruction issues with destination iss_addr.
- iss_addr  in  ADDR_W  destination being reserved.
- busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, asynchronous, independent of clock):
  - All registers clear to 0 and all busy bits clear to 0.
  - Hence rs_data=rt_data=0, rs_busy=rt_busy=0 and busy_vec=0 for any address.
  - Reset asserted mid-operation discards pending writes and reservations immediately.
  - Deassertion takes effect at the next rising edge.
- Storage: on a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. A write to address 0 is ignored.
- Reads are combinational, with zero-cycle latency:
  - rs_data = 0 when rs_addr=0.
  - Else, if BYPASS=1 and wr_en=1 and wr_addr==rs_addr, rs_data = wr_data.
  - Else rs_data = reg[rs_addr].
  - rt_data follows identical rules on rt_addr.
- Scoreboard, updated on the rising edge, per register i != 0:
  - set_i = iss_en & (iss_addr==i).
  - clr_i = wr_en & (wr_addr==i).
  - busy[i] <= set_i ? 1 : (clr_i ? 0 : busy[i]).
  - Set and clear on the same register in the same cycle leaves it busy (the newer issue wins).
  - busy[0] is constant 0; an issue to address 0 is ignored.
  - A write to a non-busy register is legal: the data is written and busy stays 0.
  - Issuing to an already-busy register is legal: it stays busy, with no counting (single outstanding write per register).
- Busy outputs:
  - rs_busy = busy[rs_addr], except that with BYPASS=1 and a same-cycle write to rs_addr it reads 0, because the data is being forwarded. rt_busy follows the same rule.
  - With BYPASS=0, rs_busy/rt_busy = busy[addr] directly.
- busy_vec is the registered scoreboard with no bypass.
- Width rules:
  - Addresses are unsigned. No wrap concerns; all NUM_REGS addresses are valid.
  - Data is stored verbatim; there is no sign extension.

Decomposition:
- Shared package regfile_pkg holds:
  - NUM_REGS derivation (function of ADDR_W).
  - ZERO_REG = 0 constant.
  - Default DATA_W/ADDR_W values shared with the ALU and datapath.
- One natural sub-module: decoder_n (ADDR_W to NUM_REGS one-hot with enable). It is instantiated twice, once for the write-enable decode and once for the issue-set decode.
- Read muxes and the bypass compare stay inline.

Test Plan:
- Reset: with reset_n=0 driven between clock edges, outputs clear immediately. Then rs_addr=3, rt_addr=5 gives rs_data=rt_data=0x00, busy_vec=0x00.
- Write then read: wr_en=1, wr_addr=2, wr_data=0xA5 at edge N. At N+1 with rs_addr=2, wr_en=0: rs_data=0xA5. With rt_addr=0: rt_data=0x00.
- Zero register: wr_en=1, wr_addr=0, wr_data=0xFF, plus iss_en=1, iss_addr=0. After the edge, rs_addr=0 gives 0x00 and busy_vec[0]=0.
- Bypass: reg4=0x11; same cycle wr_en=1, wr_addr=4, wr_data=0x22, rs_addr=4.
  - BYPASS=1: rs_data=0x22 before the edge.
  - BYPASS=0: rs_data=0x11 before the edge and 0x22 after.
- Scoreboard: iss_en=1, iss_addr=6 at edge N gives busy_vec=0x40 and rs_busy=1 for rs_addr=6. Then wr_en=1, wr_addr=6 together with iss_en=1, iss_addr=6 at edge N+1: busy_vec stays 0x40. Then wr_en=1, wr_addr=6 alone at N+2: busy_vec=0x00.
- Async reset mid-operation: busy_vec=0x0C and reg3=0x7E. Pulse reset_n low between edges: busy_vec=0x00 and reg3 reads 0x00 immediately, without any clock edge.
